// File: rtl/kg_patch_pkg.sv
// -----------------------------------------------------------------------------
// kg_patch_pkg
// Shared types and constants for the axis_frame_patch byte-rewrite engine.
//   rule_t     : one patch rule (enable, frame byte offset, value, bit mask)
//   state_e    : frame tracking state (IDLE between frames, FRAME inside one)
//   STAT_W     : width of the statistics counters
//   patch_byte : masked byte replacement helper
// The rule offset field is RULE_OFFSET_W bits wide so that any OFFSET_WIDTH up
// to 16 fits; offsets are stored zero-extended and only the low OFFSET_WIDTH
// bits take part in matching.
// -----------------------------------------------------------------------------
package kg_patch_pkg;

   localparam int unsigned STAT_W        = 32;
   localparam int unsigned RULE_OFFSET_W = 16;

   typedef struct packed {
      logic                     enable;
      logic [RULE_OFFSET_W-1:0] offset;
      logic [7:0]               value;
      logic [7:0]               mask;
   } rule_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FRAME = 1'b1
   } state_e;

   localparam rule_t RULE_RESET = '{enable: 1'b0, offset: 16'h0000, value: 8'h00, mask: 8'h00};

   // Bits set in mask take the replacement value, the rest keep the input.
   function automatic logic [7:0] patch_byte(input logic [7:0] in_byte,
                                             input logic [7:0] value,
                                             input logic [7:0] mask);
      return (in_byte & ~mask) | (value & mask);
   endfunction

endpackage

// File: rtl/axis_frame_patch_if.sv
// -----------------------------------------------------------------------------
// axis_frame_patch_if
// Single-lane AXI-stream bundle used on both sides of axis_frame_patch.
//   tdata [DATA_WIDTH], tkeep [KEEP_WIDTH], tvalid, tready, tlast, tuser
//   modport master : drives payload/valid, receives ready
//   modport slave  : receives payload/valid, drives ready
// -----------------------------------------------------------------------------
interface axis_frame_patch_if #(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int USER_WIDTH = 1
);

   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic [USER_WIDTH-1:0] tuser;

   modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);

endinterface

// File: rtl/kg_patch_lane_match.sv
// -----------------------------------------------------------------------------
// kg_patch_lane_match
// Combinational rule matcher for one byte lane.
//   rules    in  active rule set
//   beat_cnt in  beat index within the current frame
//   lane_idx in  byte lane number of this instance
//   keep     in  tkeep bit of this lane (an empty lane never hits)
//   hit      out some enabled rule targets this byte
//   value    out replacement byte of the winning rule
//   mask     out bit mask of the winning rule
// The lowest rule index wins when several rules target the same byte.
// -----------------------------------------------------------------------------
module kg_patch_lane_match
   import kg_patch_pkg::*;
#(
   parameter int RULE_COUNT   = 4,
   parameter int OFFSET_WIDTH = 14,
   parameter int LOG2K        = 6,
   parameter int BEAT_W       = OFFSET_WIDTH - LOG2K
) (
   input  rule_t             rules [RULE_COUNT],
   input  logic [BEAT_W-1:0] beat_cnt,
   input  logic [LOG2K-1:0]  lane_idx,
   input  logic              keep,
   output logic              hit,
   output logic [7:0]        value,
   output logic [7:0]        mask
);

   logic [RULE_COUNT-1:0] unused_offset_hi_s;

   // Offset bits above OFFSET_WIDTH are always zero and never compared.
   generate
      if (OFFSET_WIDTH < int'(RULE_OFFSET_W)) begin : g_hi
         for (genvar r = 0; r < RULE_COUNT; r++) begin : g_rule
            assign unused_offset_hi_s[r] = |rules[r].offset[RULE_OFFSET_W-1:OFFSET_WIDTH];
         end
      end else begin : g_no_hi
         assign unused_offset_hi_s = '0;
      end
   endgenerate

   // Scan from the highest index down so the lowest matching index is left last.
   always_comb begin
      hit   = 1'b0;
      value = 8'h00;
      mask  = 8'h00;
      for (int r = RULE_COUNT - 1; r >= 0; r--) begin
         if (rules[r].enable && keep &&
             (rules[r].offset[OFFSET_WIDTH-1:LOG2K] == beat_cnt) &&
             (rules[r].offset[LOG2K-1:0] == lane_idx)) begin
            hit   = 1'b1;
            value = rules[r].value;
            mask  = rules[r].mask;
         end else begin
            hit   = hit;
            value = value;
            mask  = mask;
         end
      end
   end

endmodule

// File: rtl/axis_frame_patch.sv
// -----------------------------------------------------------------------------
// axis_frame_patch
// Per-frame byte-rewrite engine on one AXI-stream lane with one register stage.
//   clk, rst_n            clock, asynchronous active-low reset
//   s_axis (slave)        input stream; tready = !m_valid || m_tready
//   m_axis (master)       patched stream, 1-cycle latency, full backpressure
//   cfg_wr_en/cfg_rule/cfg_enable/cfg_offset/cfg_value/cfg_mask
//                         write one rule into the shadow set
//   cfg_commit            request shadow -> active copy at the next frame gap
//   cfg_commit_pending    commit requested but not yet applied
//   stat_clear            clear statistics
//   stat_frames_patched   frames with at least one patched byte
//   stat_bytes_patched    total patched bytes
// Optional build macro KG_PATCH_STATS_EN enables the statistics counters;
// without it the stat_* outputs read zero and stat_clear is ignored.
// -----------------------------------------------------------------------------
module axis_frame_patch
   import kg_patch_pkg::*;
#(
   parameter int DATA_WIDTH   = 512,
   parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
   parameter int USER_WIDTH   = 1,
   parameter int RULE_COUNT   = 4,
   parameter int OFFSET_WIDTH = 14
) (
   input  logic                    clk,
   input  logic                    rst_n,
   axis_frame_patch_if.slave       s_axis,
   axis_frame_patch_if.master      m_axis,
   input  logic                    cfg_wr_en,
   input  logic [3:0]              cfg_rule,
   input  logic                    cfg_enable,
   input  logic [OFFSET_WIDTH-1:0] cfg_offset,
   input  logic [7:0]              cfg_value,
   input  logic [7:0]              cfg_mask,
   input  logic                    cfg_commit,
   output logic                    cfg_commit_pending,
   input  logic                    stat_clear,
   output logic [STAT_W-1:0]       stat_frames_patched,
   output logic [STAT_W-1:0]       stat_bytes_patched
);

   localparam int LOG2K  = $clog2(KEEP_WIDTH);
   localparam int BEAT_W = OFFSET_WIDTH - LOG2K;

   state_e                state_r;
   logic [BEAT_W-1:0]     beat_cnt_r;
   rule_t                 shadow_r [RULE_COUNT];
   rule_t                 active_r [RULE_COUNT];
   logic                  pending_r;

   logic [DATA_WIDTH-1:0] m_data_r;
   logic [KEEP_WIDTH-1:0] m_keep_r;
   logic                  m_valid_r;
   logic                  m_last_r;
   logic [USER_WIDTH-1:0] m_user_r;

   logic                  s_ready_s;
   logic                  accept_s;
   logic                  load_rules_s;
   logic [DATA_WIDTH-1:0] patched_data_s;
   logic [KEEP_WIDTH-1:0] lane_hit_s;

   assign s_ready_s = !m_valid_r || m_axis.tready;
   assign accept_s  = s_axis.tvalid && s_ready_s;

   // Rules swap only between frames; a last beat accepted on this edge still
   // sees the old set because matching reads active_r before the edge.
   assign load_rules_s = pending_r && (state_r == IDLE) && !(accept_s && !s_axis.tlast);

   assign s_axis.tready       = s_ready_s;
   assign m_axis.tdata        = m_data_r;
   assign m_axis.tkeep        = m_keep_r;
   assign m_axis.tvalid       = m_valid_r;
   assign m_axis.tlast        = m_last_r;
   assign m_axis.tuser        = m_user_r;
   assign cfg_commit_pending  = pending_r;

   generate
      for (genvar k = 0; k < KEEP_WIDTH; k++) begin : g_lane
         localparam logic [LOG2K-1:0] LANE_IDX = LOG2K'(k);
         logic [7:0] in_byte_s;
         logic [7:0] value_s;
         logic [7:0] mask_s;
         logic [7:0] out_byte_s;

         assign in_byte_s = s_axis.tdata[8*k +: 8];

         kg_patch_lane_match #(
            .RULE_COUNT   (RULE_COUNT),
            .OFFSET_WIDTH (OFFSET_WIDTH),
            .LOG2K        (LOG2K),
            .BEAT_W       (BEAT_W)
         ) u_match (
            .rules    (active_r),
            .beat_cnt (beat_cnt_r),
            .lane_idx (LANE_IDX),
            .keep     (s_axis.tkeep[k]),
            .hit      (lane_hit_s[k]),
            .value    (value_s),
            .mask     (mask_s)
         );

         // Empty lanes are forced to zero; hits apply the masked replacement.
         always_comb begin
            out_byte_s = 8'h00;
            if (!s_axis.tkeep[k]) begin
               out_byte_s = 8'h00;
            end else if (lane_hit_s[k]) begin
               out_byte_s = patch_byte(in_byte_s, value_s, mask_s);
            end else begin
               out_byte_s = in_byte_s;
            end
         end

         assign patched_data_s[8*k +: 8] = out_byte_s;
      end
   endgenerate

   // Output register: load on accept, drop valid once the beat is taken, hold on stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_data_r  <= '0;
         m_keep_r  <= '0;
         m_valid_r <= 1'b0;
         m_last_r  <= 1'b0;
         m_user_r  <= '0;
      end else if (accept_s) begin
         m_data_r  <= patched_data_s;
         m_keep_r  <= s_axis.tkeep;
         m_valid_r <= 1'b1;
         m_last_r  <= s_axis.tlast;
         m_user_r  <= s_axis.tuser;
      end else if (m_axis.tready) begin
         m_valid_r <= 1'b0;
      end
   end

   // Frame state machine and saturating beat counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         beat_cnt_r <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s && !s_axis.tlast) begin
                  state_r <= FRAME;
               end
            end
            FRAME: begin
               if (accept_s && s_axis.tlast) begin
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase

         if (accept_s) begin
            if (s_axis.tlast) begin
               beat_cnt_r <= '0;
            end else if (beat_cnt_r != {BEAT_W{1'b1}}) begin
               beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
            end
         end
      end
   end

   // Shadow writes, frame-aligned active load and commit bookkeeping.
   // A fresh commit on the load edge keeps pending set so it is not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < RULE_COUNT; r++) begin
            shadow_r[r] <= RULE_RESET;
            active_r[r] <= RULE_RESET;
         end
         pending_r <= 1'b0;
      end else begin
         if (load_rules_s) begin
            active_r <= shadow_r;
         end
         for (int r = 0; r < RULE_COUNT; r++) begin
            if (cfg_wr_en && (cfg_rule == 4'(r))) begin
               shadow_r[r] <= '{enable: cfg_enable,
                                offset: RULE_OFFSET_W'(cfg_offset),
                                value:  cfg_value,
                                mask:   cfg_mask};
            end
         end
         if (cfg_commit) begin
            pending_r <= 1'b1;
         end else if (load_rules_s) begin
            pending_r <= 1'b0;
         end
      end
   end

`ifdef KG_PATCH_STATS_EN
   localparam int HIT_CNT_W = $clog2(KEEP_WIDTH + 1);

   logic [HIT_CNT_W-1:0] hit_cnt_s;
   logic                 beat_hit_s;
   logic                 frame_hit_r;
   logic [STAT_W-1:0]    frames_r;
   logic [STAT_W-1:0]    bytes_r;

   assign beat_hit_s = |lane_hit_s;

   // Number of patched bytes in the beat being accepted.
   always_comb begin
      hit_cnt_s = '0;
      for (int k = 0; k < KEEP_WIDTH; k++) begin
         hit_cnt_s = hit_cnt_s + HIT_CNT_W'(lane_hit_s[k]);
      end
   end

   // Statistics counters; clear overrides a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frames_r    <= '0;
         bytes_r     <= '0;
         frame_hit_r <= 1'b0;
      end else begin
         if (accept_s) begin
            frame_hit_r <= s_axis.tlast ? 1'b0 : (frame_hit_r || beat_hit_s);
         end
         if (stat_clear) begin
            frames_r <= '0;
            bytes_r  <= '0;
         end else if (accept_s) begin
            bytes_r <= bytes_r + STAT_W'(hit_cnt_s);
            if (s_axis.tlast && (frame_hit_r || beat_hit_s)) begin
               frames_r <= frames_r + STAT_W'(1);
            end
         end
      end
   end

   assign stat_frames_patched = frames_r;
   assign stat_bytes_patched  = bytes_r;
`else
   logic unused_stat_s;

   assign unused_stat_s       = stat_clear ^ (|lane_hit_s);
   assign stat_frames_patched = '0;
   assign stat_bytes_patched  = '0;
`endif

endmodule

// File: tb/tb_axis_frame_patch.sv
// -----------------------------------------------------------------------------
// tb_axis_frame_patch
// Directed bench for axis_frame_patch (default parameters, 64 byte lanes).
// Expected beats are queued by the sender and compared by a negedge monitor.
// Statistics expectations apply when KG_PATCH_STATS_EN is defined, else zero.
// -----------------------------------------------------------------------------
module tb_axis_frame_patch;

   localparam int DW = 512;
   localparam int KW = 64;
   localparam int UW = 1;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
      logic [UW-1:0] user;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cfg_wr_en, cfg_enable, cfg_commit, cfg_commit_pending, stat_clear;
   logic [3:0]  cfg_rule;
   logic [13:0] cfg_offset;
   logic [7:0]  cfg_value, cfg_mask;
   logic [31:0] stat_frames_patched, stat_bytes_patched;

   axis_frame_patch_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) s_if ();
   axis_frame_patch_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) m_if ();

   axis_frame_patch #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
                      .RULE_COUNT(4), .OFFSET_WIDTH(14)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .s_axis              (s_if),
      .m_axis              (m_if),
      .cfg_wr_en           (cfg_wr_en),
      .cfg_rule            (cfg_rule),
      .cfg_enable          (cfg_enable),
      .cfg_offset          (cfg_offset),
      .cfg_value           (cfg_value),
      .cfg_mask            (cfg_mask),
      .cfg_commit          (cfg_commit),
      .cfg_commit_pending  (cfg_commit_pending),
      .stat_clear          (stat_clear),
      .stat_frames_patched (stat_frames_patched),
      .stat_bytes_patched  (stat_bytes_patched)
   );

   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_fail = 0;
   int    exp_frames = 0;
   int    exp_bytes = 0;
   bit    bp_en = 1'b0;
   beat_t exp_q [$];
   beat_t mon_b;
   logic  held_v = 1'b0;
   logic [DW-1:0] held_d;

   task automatic check_eq(input string tag, input logic [639:0] got, input logic [639:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_stats(input string tag);
`ifdef KG_PATCH_STATS_EN
      check_eq({tag, "_frames"}, stat_frames_patched, exp_frames);
      check_eq({tag, "_bytes"}, stat_bytes_patched, exp_bytes);
`else
      check_eq({tag, "_frames_off"}, stat_frames_patched, 0);
      check_eq({tag, "_bytes_off"}, stat_bytes_patched, 0);
`endif
   endtask

   task automatic cfg_write(input logic [3:0] idx, input logic en, input logic [13:0] off,
                            input logic [7:0] v, input logic [7:0] m, input logic cm);
      cfg_wr_en = 1'b1; cfg_rule = idx; cfg_enable = en;
      cfg_offset = off; cfg_value = v; cfg_mask = m; cfg_commit = cm;
      @(posedge clk); #1;
      cfg_wr_en = 1'b0; cfg_commit = 1'b0;
   endtask

   task automatic commit_now(input string tag);
      cfg_commit = 1'b1;
      @(posedge clk); #1;
      cfg_commit = 1'b0;
      @(posedge clk); #1;
      check_eq(tag, cfg_commit_pending, 0);
   endtask

   // Present one beat until accepted (bounded), then queue its expected output.
   task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                            input logic [DW-1:0] e, input logic cm);
      bit ok = 1'b0;
      s_if.tdata = d; s_if.tkeep = k; s_if.tlast = l; s_if.tuser = UW'(l);
      s_if.tvalid = 1'b1; cfg_commit = cm;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk);
         ok = s_if.tready;
         @(posedge clk); #1;
         if (ok) exp_q.push_back('{data: e, keep: k, last: l, user: UW'(l)});
      end
      s_if.tvalid = 1'b0; cfg_commit = 1'b0;
      if (!ok) check_eq("accept_timeout", 0, 1);
      else     check_eq("valid_after_accept", m_if.tvalid, 1);
   endtask

   task automatic wait_drain(input string tag);
      for (int c = 0; c < 40 && exp_q.size() != 0; c++) @(posedge clk);
      #1;
      check_eq(tag, exp_q.size(), 0);
   endtask

   // Output monitor: beat-for-beat compare, hold-under-stall, ready during stall.
   always @(negedge clk) begin
      if (rst_n && m_if.tvalid) begin
         if (held_v) check_eq("hold_data", m_if.tdata, held_d);
         if (!m_if.tready) begin
            check_eq("s_ready_in_stall", s_if.tready, 0);
            held_v <= 1'b1;
            held_d <= m_if.tdata;
         end else begin
            held_v <= 1'b0;
            if (exp_q.size() == 0) begin
               check_eq("unexpected_beat", 1, 0);
            end else begin
               mon_b = exp_q.pop_front();
               check_eq("beat_data", m_if.tdata, mon_b.data);
               check_eq("beat_ctl", {m_if.tlast, m_if.tuser, m_if.tkeep},
                        {mon_b.last, mon_b.user, mon_b.keep});
            end
         end
      end else begin
         held_v <= 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] d, e;
      logic [KW-1:0] ones;
      ones = '1;
      s_if.tdata = '0; s_if.tkeep = '0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tuser = '0;
      m_if.tready = 1'b1;
      cfg_wr_en = 1'b0; cfg_rule = 4'h0; cfg_enable = 1'b0; cfg_offset = 14'h0;
      cfg_value = 8'h00; cfg_mask = 8'h00; cfg_commit = 1'b0; stat_clear = 1'b0;

      // Reset state
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_m_valid", m_if.tvalid, 0);
      check_eq("rst_m_data", m_if.tdata, 0);
      check_eq("rst_m_ctl", {m_if.tlast, m_if.tkeep}, 0);
      check_eq("rst_pending", cfg_commit_pending, 0);
      check_eq("rst_s_ready", s_if.tready, 1);
      check_stats("rst");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single-lane patch
      cfg_write(4'd0, 1'b1, 14'd5, 8'hAB, 8'hFF, 1'b0);
      commit_now("t1_commit");
      d = '0; e = '0; e[5*8 +: 8] = 8'hAB;
      send_beat(d, ones, 1'b1, e, 1'b0);
      wait_drain("t1_drain");
      exp_frames = 1; exp_bytes = 1;
      check_stats("t1");

      // Cross-beat offset with partial mask
      cfg_write(4'd0, 1'b0, 14'd0, 8'h00, 8'h00, 1'b0);
      cfg_write(4'd1, 1'b1, 14'd70, 8'hF0, 8'h0F, 1'b0);
      commit_now("t2_commit");
      d = {64{8'h55}};
      send_beat(d, ones, 1'b0, d, 1'b0);
      e = d; e[6*8 +: 8] = 8'h50;
      send_beat(d, ones, 1'b0, e, 1'b0);
      send_beat(d, ones, 1'b1, d, 1'b0);
      wait_drain("t2_drain");
      exp_frames = 2; exp_bytes = 2;
      check_stats("t2");

      // Priority and tkeep
      cfg_write(4'd0, 1'b1, 14'd3, 8'h11, 8'hFF, 1'b0);
      cfg_write(4'd2, 1'b1, 14'd3, 8'h22, 8'hFF, 1'b0);
      cfg_write(4'd1, 1'b1, 14'd74, 8'h77, 8'hFF, 1'b0);
      commit_now("t3_commit");
      d = {64{8'hAA}};
      e = d; e[3*8 +: 8] = 8'h11;
      send_beat(d, ones, 1'b0, e, 1'b0);
      e = '0; e[31:0] = {4{8'hAA}};
      send_beat(d, 64'h0F, 1'b1, e, 1'b0);
      wait_drain("t3_drain");
      exp_frames = 3; exp_bytes = 3;
      check_stats("t3");

      // Frame-aligned commit
      cfg_write(4'd0, 1'b0, 14'd0, 8'h00, 8'h00, 1'b0);
      cfg_write(4'd1, 1'b0, 14'd0, 8'h00, 8'h00, 1'b0);
      cfg_write(4'd2, 1'b0, 14'd0, 8'h00, 8'h00, 1'b0);
      cfg_write(4'd3, 1'b1, 14'd2, 8'h33, 8'hFF, 1'b0);
      check_eq("t4_pend_idle", cfg_commit_pending, 0);
      d = '0;
      e = '0; e[3*8 +: 8] = 8'h11;
      send_beat(d, ones, 1'b0, e, 1'b0);
      e = '0; e[10*8 +: 8] = 8'h77;
      send_beat(d, ones, 1'b0, e, 1'b1);
      check_eq("t4_pend_b1", cfg_commit_pending, 1);
      send_beat(d, ones, 1'b0, '0, 1'b0);
      check_eq("t4_pend_b2", cfg_commit_pending, 1);
      send_beat(d, ones, 1'b1, '0, 1'b0);
      check_eq("t4_pend_tlast", cfg_commit_pending, 1);
      @(posedge clk); #1;
      check_eq("t4_pend_applied", cfg_commit_pending, 0);
      e = '0; e[2*8 +: 8] = 8'h33;
      send_beat(d, ones, 1'b1, e, 1'b0);
      wait_drain("t4_drain");
      exp_frames = 5; exp_bytes = 6;
      check_stats("t4");

      // Backpressure: ready toggles every cycle over a 10-beat frame
      cfg_write(4'd3, 1'b0, 14'd0, 8'h00, 8'h00, 1'b0);
      cfg_write(4'd0, 1'b1, 14'd200, 8'hCC, 8'hFF, 1'b0);
      commit_now("t5_commit");
      bp_en = 1'b1;
      fork
         begin
            while (bp_en) begin
               @(posedge clk); #1;
               m_if.tready = ~m_if.tready;
            end
            m_if.tready = 1'b1;
         end
         begin
            for (int i = 0; i < 10; i++) begin
               d = {64{8'(i + 1)}};
               e = d;
               if (i == 3) e[8*8 +: 8] = 8'hCC;
               send_beat(d, ones, (i == 9), e, 1'b0);
            end
            bp_en = 1'b0;
         end
      join
      wait_drain("t5_drain");
      exp_frames = 6; exp_bytes = 7;
      check_stats("t5");

      // Reset mid-frame
      d = '0;
      send_beat(d, ones, 1'b0, d, 1'b0);
      send_beat(d, ones, 1'b0, d, 1'b0);
      s_if.tdata = d; s_if.tkeep = ones; s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check_eq("t6_valid_in_rst", m_if.tvalid, 0);
      exp_q.delete();
      exp_frames = 0; exp_bytes = 0;
      check_eq("t6_pend_in_rst", cfg_commit_pending, 0);
      check_stats("t6_rst");
      s_if.tvalid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("t6_s_ready", s_if.tready, 1);
      commit_now("t6_commit_empty");
      d = {64{8'h3C}};
      for (int i = 0; i < 4; i++) send_beat(d, ones, (i == 3), d, 1'b0);
      wait_drain("t6_drain_a");
      check_stats("t6_unpatched");
      cfg_write(4'd5, 1'b1, 14'd0, 8'h99, 8'hFF, 1'b0);
      cfg_write(4'd0, 1'b1, 14'd1, 8'hEE, 8'hFF, 1'b1);
      check_eq("t6_pend_wr_commit", cfg_commit_pending, 1);
      @(posedge clk); #1;
      check_eq("t6_pend_applied", cfg_commit_pending, 0);
      e = d; e[1*8 +: 8] = 8'hEE;
      send_beat(d, ones, 1'b1, e, 1'b0);
      wait_drain("t6_drain_b");
      exp_frames = 1; exp_bytes = 1;
      check_stats("t6_patched");

      // Statistics clear
      stat_clear = 1'b1;
      @(posedge clk); #1;
      stat_clear = 1'b0;
      exp_frames = 0; exp_bytes = 0;
      check_stats("clear");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_frame_patch.md
Name: axis_frame_patch

Overview:
- Parametrised per-frame byte-rewrite engine on a single AXI-stream lane.
- Successor to the single-rule, combinational, 64-byte-window patcher. Adds:
  - RULE_COUNT independent rules;
  - frame-relative byte offsets that span beats;
  - per-bit masking;
  - atomic, frame-aligned rule updates;
  - one registered stage with full backpressure.
- Sits between the MAC-side pad/FIFO and the CMAC tx (or rx) path; one instance per direction per port.

Parameters:
- DATA_WIDTH, 512, stream data width in bits; must be a multiple of 8, and KEEP_WIDTH must be a power of two.
- KEEP_WIDTH, DATA_WIDTH/8, byte lanes per beat.
- USER_WIDTH, 1, tuser width, passed through unchanged.
- RULE_COUNT, 4, number of patch rules (1..16).
- OFFSET_WIDTH, 14, width of the frame byte offset; offsets 0..2^OFFSET_WIDTH-1.

Ports:
- clk  in  1  Single clock; all logic synchronous to it.
- rst_n  in  1  Asynchronous reset, active-low.
- s_axis_tdata  in  DATA_WIDTH  Input beat data.
- s_axis_tkeep  in  KEEP_WIDTH  Input byte enables.
- s_axis_tvalid  in  1  Input valid.
- s_axis_tready  out  1  Input ready.
- s_axis_tlast  in  1  Input end of frame.
- s_axis_tuser  in  USER_WIDTH  Input sideband.
- m_axis_tdata  out  DATA_WIDTH  Patched data.
- m_axis_tkeep  out  KEEP_WIDTH  Copy of tkeep.
- m_axis_tvalid  out  1  Output valid.
- m_axis_tready  in  1  Output ready.
- m_axis_tlast  out  1  Output end of frame.
- m_axis_tuser  out  USER_WIDTH  Output sideband.
- cfg_wr_en  in  1  Write one rule into the shadow set.
- cfg_rule  in  4  Rule index; writes with index >= RULE_COUNT are ignored.
- cfg_enable  in  1  Rule enable.
- cfg_offset  in  OFFSET_WIDTH  Frame byte offset the rule targets.
- cfg_value  in  8  Replacement byte.
- cfg_mask  in  8  Bits to replace (1 = take cfg_value).
- cfg_commit  in  1  Request to copy the shadow set into the active set.
- cfg_commit_pending  out  1  Commit requested and not yet applied.
- stat_clear  in  1  Clear the statistics counters.
- stat_frames_patched  out  32  Frames with at least one patched byte.
- stat_bytes_patched  out  32  Total patched bytes.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - m_axis_tvalid = 0, other m_axis_* = 0;
  - beat counter = 0; state IDLE;
  - shadow and active rules all disabled, offset/value/mask = 0;
  - cfg_commit_pending = 0; stats = 0.
- Pipeline:
  - One register stage; latency 1 cycle from s-side accept to m_axis_tvalid.
  - s_axis_tready = !m_axis_tvalid || m_axis_tready.
  - An output beat holds stable while tvalid && !tready.
  - Full throughput: 1 beat per cycle.
- Beat counter:
  - Increments on each accepted beat and clears on an accepted beat with tlast.
  - Saturates at its maximum; it never wraps.
- States:
  - IDLE -> FRAME on an accepted beat without tlast.
  - FRAME -> IDLE on an accepted beat with tlast.
  - A single-beat frame stays in IDLE.
- Matching, per lane k (LOG2K = log2(KEEP_WIDTH)):
  - rule r hits when: active enable[r], offset[r][OFFSET_WIDTH-1:LOG2K] == beat counter, offset[r][LOG2K-1:0] == k, and tkeep[k] = 1.
  - If several rules hit the same byte, the lowest index wins.
  - Patched byte = (in & ~mask) | (value & mask).
  - A hit with mask = 0 is still counted as patched.
- Lanes with tkeep[k] = 0 output 8'h00 and are never patched. A rule whose offset lies beyond the frame end therefore has no effect.
- Configuration:
  - cfg_wr_en writes the shadow set only.
  - cfg_commit sets pending.
  - The active set is loaded from shadow at a clock edge where pending = 1 and state = IDLE and no non-last beat is being accepted; pending clears at that edge.
  - A beat accepted on the load edge uses the old active set.
  - A commit during FRAME waits for the frame to end.
  - cfg_wr_en and commit in the same cycle: the write lands in shadow first, then pending is set.
- Reset mid-frame: the output beat is discarded, state returns to IDLE and rules are disabled; the downstream sees a truncated frame (accepted behaviour).
- Statistics (only with the feature enabled):
  - Both counters update on the output-register load and wrap modulo 2^32.
  - stat_frames_patched increments once per frame, on its last beat, if any beat of the frame hit.
  - stat_clear has priority over a same-cycle increment.

Optional Feature:
- Macro: KG_PATCH_STATS_EN.
- Defined: the statistics counters and a per-frame hit flag are implemented as above.
- Undefined: stat_* outputs are tied to 0, stat_clear is ignored, and no counter logic is generated.
- Datapath behaviour is identical in both builds.

Decomposition:
- Package kg_patch_pkg holds:
  - the rule struct typedef (enable, offset, value, mask);
  - the state enum (IDLE, FRAME);
  - the stats counter width constant (32).
- Sub-module kg_patch_lane_match: combinational; takes the rule vector, beat counter, lane index and tkeep bit; returns hit, winning value and winning mask. Instantiated KEEP_WIDTH times.

Test Plan:
- Single-lane patch: rule0 = {en, offset 5, value 8'hAB, mask 8'hFF}, commit; send a 64-byte frame of 8'h00 -> only byte 5 = 8'hAB; with stats, frames_patched = 1, bytes_patched = 1.
- Cross-beat offset with partial mask: rule1 = {offset 70, value 8'hF0, mask 8'h0F}; 3-beat frame of 8'h55 -> beat 1 lane 6 = 8'h50, all other bytes 8'h55; latency 1 cycle.
- Priority and tkeep: rules 0 and 2 both target offset 3 with values 8'h11 and 8'h22 -> output 8'h11. Final beat tkeep = 64'h0F with a rule at lane 10 -> lanes 4..63 = 0 and no patch counted.
- Frame-aligned commit: commit issued on beat 1 of a 4-beat frame -> that frame uses the old rules, the next frame uses the new ones; cfg_commit_pending is high until after the tlast beat.
- Backpressure: m_axis_tready toggles 1010… over a 10-beat frame -> data matches a golden model beat for beat, with no drop or duplicate; s_axis_tready = 0 whenever the output is stalled.
- Reset mid-frame: assert rst_n low on beat 2 -> m_axis_tvalid = 0 immediately; after release, a new frame is unpatched until a rule is written and committed.
